// File: rtl/craps_autoplayer_if.sv
// craps_autoplayer_if: control, game-controller and tally signals of the craps autoplayer
interface craps_autoplayer_if;
  logic start, win, lose, roll, game_rst, busy, done, err;
  logic [7:0] wins, losses;
  logic [11:0] presses;
  modport master (input start, win, lose, output roll, game_rst, busy, done, err, wins, losses, presses);
  modport slave (output start, win, lose, input roll, game_rst, busy, done, err, wins, losses, presses);
endinterface

// File: rtl/craps_autoplayer.sv
// craps_autoplayer: plays NUM_GAMES craps games unattended via roll/game_rst and tallies outcomes
module craps_autoplayer #(
  parameter int NUM_GAMES = 16,
  parameter int HOLD_MIN = 4,
  parameter int HOLD_W = 4,
  parameter int GAP_CYC = 3,
  parameter int SETTLE = 4
) (
  input logic clk,
  input logic rst,
  craps_autoplayer_if.master bus
);
  localparam int CW = $clog2(HOLD_MIN + (1 << HOLD_W) + GAP_CYC + SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_GAP, S_PRESS, S_SETTLE, S_RESULT, S_CLEAR, S_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, hold, lim;
  logic [15:0] lfsr;
  logic [7:0] games;
  logic last, flag, enter, sample, roll_d, game_rst_d, busy_d, done_d;
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    lim = state == S_GAP ? CW'(GAP_CYC) : state == S_PRESS ? hold : CW'(SETTLE);
    last = cnt == lim - CW'(1);
    flag = bus.win | bus.lose;
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = bus.start ? S_INIT : state;
      S_INIT: state_n = S_GAP;
      S_GAP: state_n = last ? S_PRESS : S_GAP;
      S_PRESS: state_n = last ? S_SETTLE : S_PRESS;
      S_SETTLE: state_n = last ? (flag ? S_RESULT : S_GAP) : S_SETTLE;
      S_RESULT: state_n = S_CLEAR;
      S_CLEAR: state_n = flag ? S_CLEAR : games == 8'(NUM_GAMES) ? S_DONE : S_GAP;
      default: state_n = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    roll_d = state_n == S_PRESS;
    game_rst_d = state_n == S_INIT || state_n == S_RESULT;
    busy_d = state_n != S_IDLE && state_n != S_DONE;
    done_d = state_n == S_DONE;
    enter = state_n != state;
    sample = state == S_SETTLE && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.roll <= 1'b0;
      bus.game_rst <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.wins <= '0;
      bus.losses <= '0;
      bus.presses <= '0;
      cnt <= '0;
      hold <= '0;
      games <= '0;
      lfsr <= 16'hACE1;
    end else begin
      bus.roll <= roll_d;
      bus.game_rst <= game_rst_d;
      bus.busy <= busy_d;
      bus.done <= done_d;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cnt <= enter ? '0 : cnt + CW'(1);
      if (enter && state_n == S_GAP) hold <= CW'(HOLD_MIN) + CW'(lfsr[HOLD_W-1:0]);
      if (enter && state_n == S_INIT) begin
        bus.err <= 1'b0;
        bus.wins <= '0;
        bus.losses <= '0;
        bus.presses <= '0;
        games <= '0;
      end else begin
        if (enter && state_n == S_PRESS && bus.presses != '1) bus.presses <= bus.presses + 12'd1;
        if (sample && bus.win && bus.lose) bus.err <= 1'b1;
        if (sample && bus.win && bus.wins != '1) bus.wins <= bus.wins + 8'd1;
        if (sample && !bus.win && bus.lose && bus.losses != '1) bus.losses <= bus.losses + 8'd1;
        if (state == S_RESULT) games <= games + 8'd1;
      end
    end
  end
endmodule
